rstreq: RTL and testbench

Reset-request initiator for the system clock/reset generator. Gathers the three warm-reset sources (debounced front-panel button, watchdog timeout, software request) and drives the generator's `trigger_reset` input with a fixed-length pulse, then holds off new requests while the generator's reset stretch completes. Runs on `sys_clk` and is reset only by the power-on reset `sys_rst_n`, never by the `sys_rst` it causes, so the recorded cause survives the warm reset for software to read.

---
 rtl/rstreq.sv | 162 ++++++++++++++++
 tb/tb_rstreq.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rstreq.sv
// Warm-reset request initiator: merges button, watchdog and software sources into a
// fixed-length trigger_reset pulse followed by a holdoff; lives on power-on reset only.
module rstreq #(
   parameter int unsigned PULSE_LEN  = 16,
   parameter int unsigned HOLDOFF    = 1048576,
   parameter int unsigned BTN_CYCLES = 1000000,
   parameter int unsigned WDT_WIDTH  = 32
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 btn_n,
   input  logic                 soft_req,
   input  logic                 wdt_en,
   input  logic                 wdt_kick,
   input  logic [WDT_WIDTH-1:0] wdt_reload,
   output logic                 trigger_reset,
   output logic                 busy,
   output logic [1:0]           last_cause,
   output logic [WDT_WIDTH-1:0] wdt_count
);

   // state      | meaning
   // ST_IDLE    | armed; accepts the highest-priority pending request
   // ST_ASSERT  | trigger_reset high for PULSE_LEN cycles
   // ST_HOLDOFF | generator stretch in progress; requests dropped

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE = 2'b00,
      CAUSE_BTN  = 2'b01,
      CAUSE_WDT  = 2'b10,
      CAUSE_SOFT = 2'b11
   } cause_e;

   localparam int unsigned DB_W    = $clog2(BTN_CYCLES);
   localparam int unsigned CNT_MAX = (PULSE_LEN > HOLDOFF) ? PULSE_LEN : HOLDOFF;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(BTN_CYCLES - 1);
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD  = (HOLDOFF == 0) ? '0 : CNT_W'(HOLDOFF - 1);

   logic                 sync1_q, sync1_d;
   logic                 sync2_q, sync2_d;
   logic                 btn_db_q, btn_db_d;
   logic [DB_W-1:0]      db_cnt_q, db_cnt_d;
   logic                 btn_req_q, btn_req_d;
   logic [WDT_WIDTH-1:0] wdt_cnt_q, wdt_cnt_d;
   logic                 wdt_req;
   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   cause_e               cause_q, cause_d;
   logic                 trigger_q, trigger_d;
   logic                 busy_q, busy_d;

   // Button: synchronise, then require BTN_CYCLES stable samples before accepting a level
   always_comb begin
      sync1_d  = btn_n;
      sync2_d  = sync1_q;
      btn_db_d = btn_db_q;
      db_cnt_d = db_cnt_q;
      if (sync2_q == btn_db_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
         btn_db_d = sync2_q;
         db_cnt_d = '0;
      end else begin
         db_cnt_d = db_cnt_q + DB_W'(1);
      end
      btn_req_d = btn_db_q & ~btn_db_d;
   end

   // Watchdog only counts while armed in IDLE, so it restarts fresh after every reset cycle
   always_comb begin
      wdt_cnt_d = wdt_cnt_q;
      wdt_req   = 1'b0;
      if (!wdt_en || (state_q != ST_IDLE)) begin
         wdt_cnt_d = wdt_reload;
      end else if (wdt_kick) begin
         wdt_cnt_d = wdt_reload;
      end else if (wdt_cnt_q == '0) begin
         wdt_req = 1'b1;
      end else begin
         wdt_cnt_d = wdt_cnt_q - WDT_WIDTH'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      case (state_q)
         ST_IDLE: begin
            if (btn_req_q || wdt_req || soft_req) begin
               state_d = ST_ASSERT;
               cnt_d   = PULSE_LOAD;
               if (btn_req_q)    cause_d = CAUSE_BTN;
               else if (wdt_req) cause_d = CAUSE_WDT;
               else              cause_d = CAUSE_SOFT;
            end
         end
         ST_ASSERT: begin
            if (cnt_q == '0) begin
               if (HOLDOFF == 0) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_HOLDOFF;
                  cnt_d   = HOLD_LOAD;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_HOLDOFF: begin
            if (cnt_q == '0) state_d = ST_IDLE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase
      trigger_d = (state_d == ST_ASSERT);
      busy_d    = (state_d != ST_IDLE);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         btn_db_q  <= 1'b1;
         db_cnt_q  <= '0;
         btn_req_q <= 1'b0;
         wdt_cnt_q <= '0;
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         cause_q   <= CAUSE_NONE;
         trigger_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         btn_db_q  <= btn_db_d;
         db_cnt_q  <= db_cnt_d;
         btn_req_q <= btn_req_d;
         wdt_cnt_q <= wdt_cnt_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cause_q   <= cause_d;
         trigger_q <= trigger_d;
         busy_q    <= busy_d;
      end
   end

   assign trigger_reset = trigger_q;
   assign busy          = busy_q;
   assign last_cause    = cause_q;
   assign wdt_count     = wdt_cnt_q;

endmodule

// File: tb/tb_rstreq.sv
// Scoreboard bench for rstreq: each expected pulse (cause, start-cycle window) is queued
// when its stimulus is driven and popped by the monitor when trigger_reset rises.
module tb_rstreq;

   localparam int P   = 4;
   localparam int H   = 8;
   localparam int BTN = 5;
   localparam int WW  = 8;

   logic          sys_clk    = 1'b0;
   logic          sys_rst_n  = 1'b1;
   logic          btn_n      = 1'b1;
   logic          soft_req   = 1'b0;
   logic          wdt_en     = 1'b0;
   logic          wdt_kick   = 1'b0;
   logic [WW-1:0] wdt_reload = 8'd20;
   logic          trigger_reset;
   logic          busy;
   logic [1:0]    last_cause;
   logic [WW-1:0] wdt_count;

   int checks    = 0;
   int failures  = 0;
   int cyc       = 0;
   int pulse_cnt = 0;

   typedef struct {
      logic [1:0] cause;
      int         min_cyc;
      int         max_cyc;
   } exp_t;
   exp_t exp_q[$];

   rstreq #(
      .PULSE_LEN (P),
      .HOLDOFF   (H),
      .BTN_CYCLES(BTN),
      .WDT_WIDTH (WW)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .btn_n        (btn_n),
      .soft_req     (soft_req),
      .wdt_en       (wdt_en),
      .wdt_kick     (wdt_kick),
      .wdt_reload   (wdt_reload),
      .trigger_reset(trigger_reset),
      .busy         (busy),
      .last_cause   (last_cause),
      .wdt_count    (wdt_count)
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   // Monitor: cyc at a negedge names the posedge that produced the sampled outputs
   logic prev_trig = 1'b0;
   logic prev_busy = 1'b0;
   int   hi_len    = 0;
   int   busy_len  = 0;
   always @(negedge sys_clk) begin
      if (!sys_rst_n) begin
         prev_trig = 1'b0;
         prev_busy = 1'b0;
         hi_len    = 0;
         busy_len  = 0;
      end else begin
         if (trigger_reset && !prev_trig) begin
            exp_t e;
            pulse_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_pulse cyc=%0d cause=%0d, no pulse was expected", cyc, last_cause);
            end else begin
               e = exp_q.pop_front();
               checks++;
               if (last_cause !== e.cause) begin
                  failures++;
                  $display("FAIL pulse_cause cyc=%0d got=%0d exp=%0d", cyc, last_cause, e.cause);
               end
               checks++;
               if (cyc < e.min_cyc || cyc > e.max_cyc) begin
                  failures++;
                  $display("FAIL pulse_start got=%0d exp=%0d..%0d", cyc, e.min_cyc, e.max_cyc);
               end
            end
         end
         if (trigger_reset) hi_len++;
         else if (prev_trig) begin
            checks++;
            if (hi_len != P) begin
               failures++;
               $display("FAIL pulse_len cyc=%0d got=%0d exp=%0d", cyc, hi_len, P);
            end
            hi_len = 0;
         end
         if (busy) busy_len++;
         else if (prev_busy) begin
            checks++;
            if (busy_len != P + H) begin
               failures++;
               $display("FAIL busy_len cyc=%0d got=%0d exp=%0d", cyc, busy_len, P + H);
            end
            busy_len = 0;
         end
         prev_trig = trigger_reset;
         prev_busy = busy;
      end
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic test_reset();
      #2 sys_rst_n = 1'b0;
      #1;
      checks += 4;
      if (trigger_reset !== 1'b0) begin failures++; $display("FAIL rst_trigger got=%b exp=0", trigger_reset); end
      if (busy !== 1'b0)          begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
      if (last_cause !== 2'b00)   begin failures++; $display("FAIL rst_cause got=%0d exp=0", last_cause); end
      if (wdt_count !== 8'd0)     begin failures++; $display("FAIL rst_wdt_count got=%0d exp=0", wdt_count); end
      tick(); tick();
      sys_rst_n = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_soft_req();
      int n;
      n = cyc + 1;
      exp_q.push_back('{2'b11, n, n});
      soft_req = 1'b1;
      tick();
      soft_req = 1'b0;
      for (int i = 0; i <= P + H; i++) begin
         logic et, eb;
         et = (i < P) ? 1'b1 : 1'b0;
         eb = (i < P + H) ? 1'b1 : 1'b0;
         checks += 3;
         if (trigger_reset !== et) begin failures++; $display("FAIL soft_trigger i=%0d got=%b exp=%b", i, trigger_reset, et); end
         if (busy !== eb)          begin failures++; $display("FAIL soft_busy i=%0d got=%b exp=%b", i, busy, eb); end
         if (last_cause !== 2'b11) begin failures++; $display("FAIL soft_cause i=%0d got=%0d exp=3", i, last_cause); end
         tick();
      end
      repeat (3) tick();
      checks += 2;
      if (last_cause !== 2'b11) begin failures++; $display("FAIL soft_sticky got=%0d exp=3", last_cause); end
      if (exp_q.size() != 0)    begin failures++; $display("FAIL soft_missing got=%0d pending exp=0", exp_q.size()); end
   endtask

   task automatic test_back_to_back();
      int n;
      n = cyc + 1;
      exp_q.push_back('{2'b11, n, n});
      soft_req = 1'b1;
      tick();
      soft_req = 1'b0;
      repeat (P + H - 1) tick();
      soft_req = 1'b1;
      tick();
      checks += 2;
      if (busy !== 1'b0)          begin failures++; $display("FAIL b2b_drop_busy got=%b exp=0", busy); end
      if (trigger_reset !== 1'b0) begin failures++; $display("FAIL b2b_drop_trigger got=%b exp=0", trigger_reset); end
      exp_q.push_back('{2'b11, n + P + H + 1, n + P + H + 1});
      tick();
      soft_req = 1'b0;
      checks++;
      if (trigger_reset !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", trigger_reset); end
      repeat (P + H + 2) tick();
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_missing got=%0d pending exp=0", exp_q.size()); end
   endtask

   task automatic test_wdt_expire();
      int c, first_zero;
      wdt_reload = 8'd20;
      tick();
      c = cyc;
      wdt_en = 1'b1;
      exp_q.push_back('{2'b10, c + 21, c + 21});
      first_zero = -1;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (wdt_count == 8'd0 && first_zero < 0) first_zero = cyc;
      end
      wdt_en = 1'b0;
      repeat (P + H + 2) tick();
      checks += 3;
      if (first_zero != c + 20) begin failures++; $display("FAIL wdt_zero_cyc got=%0d exp=%0d", first_zero, c + 20); end
      if (last_cause !== 2'b10) begin failures++; $display("FAIL wdt_cause got=%0d exp=2", last_cause); end
      if (exp_q.size() != 0)    begin failures++; $display("FAIL wdt_missing got=%0d pending exp=0", exp_q.size()); end
   endtask

   task automatic test_wdt_kick();
      int p0;
      p0 = pulse_cnt;
      wdt_reload = 8'd20;
      wdt_en = 1'b1;
      wdt_kick = 1'b1;
      tick();
      wdt_kick = 1'b0;
      for (int i = 1; i <= 500; i++) begin
         tick();
         wdt_kick = (i % 15 == 0) ? 1'b1 : 1'b0;
      end
      wdt_kick = 1'b0;
      wdt_en = 1'b0;
      tick();
      checks += 2;
      if (pulse_cnt != p0)        begin failures++; $display("FAIL kick_pulses got=%0d exp=%0d", pulse_cnt, p0); end
      if (wdt_count !== 8'd20)    begin failures++; $display("FAIL kick_reload got=%0d exp=20", wdt_count); end
   endtask

   task automatic test_simultaneous();
      int c, p0;
      p0 = pulse_cnt;
      c = cyc;
      btn_n = 1'b0;
      exp_q.push_back('{2'b01, c + BTN + 3, c + BTN + 3});
      repeat (BTN + 2) tick();
      soft_req = 1'b1;
      tick();
      soft_req = 1'b0;
      checks++;
      if (last_cause !== 2'b01) begin failures++; $display("FAIL simul_cause got=%0d exp=1", last_cause); end
      repeat (P + 1) tick();
      soft_req = 1'b1;
      tick();
      soft_req = 1'b0;
      btn_n = 1'b1;
      repeat (25) tick();
      checks += 3;
      if (pulse_cnt != p0 + 1)  begin failures++; $display("FAIL simul_pulses got=%0d exp=%0d", pulse_cnt, p0 + 1); end
      if (last_cause !== 2'b01) begin failures++; $display("FAIL holdoff_drop_cause got=%0d exp=1", last_cause); end
      if (exp_q.size() != 0)    begin failures++; $display("FAIL simul_missing got=%0d pending exp=0", exp_q.size()); end
   endtask

   task automatic test_button_bounce();
      int p0;
      p0 = pulse_cnt;
      btn_n = 1'b0; repeat (3) tick();
      btn_n = 1'b1; tick();
      btn_n = 1'b0; repeat (3) tick();
      btn_n = 1'b1;
      repeat (20) tick();
      checks++;
      if (pulse_cnt != p0) begin failures++; $display("FAIL bounce_pulses got=%0d exp=%0d", pulse_cnt, p0); end
   endtask

   task automatic test_button_press();
      int c, p0;
      p0 = pulse_cnt;
      c = cyc;
      btn_n = 1'b0;
      exp_q.push_back('{2'b01, c + BTN + 2, c + BTN + 4});
      repeat (40) tick();
      checks += 2;
      if (pulse_cnt != p0 + 1)  begin failures++; $display("FAIL held_pulses got=%0d exp=%0d", pulse_cnt, p0 + 1); end
      if (last_cause !== 2'b01) begin failures++; $display("FAIL btn_cause got=%0d exp=1", last_cause); end
      btn_n = 1'b1;
      repeat (BTN + 5) tick();
      checks++;
      if (pulse_cnt != p0 + 1) begin failures++; $display("FAIL release_pulses got=%0d exp=%0d", pulse_cnt, p0 + 1); end
      c = cyc;
      btn_n = 1'b0;
      exp_q.push_back('{2'b01, c + BTN + 2, c + BTN + 4});
      repeat (25) tick();
      btn_n = 1'b1;
      repeat (12) tick();
      checks += 2;
      if (pulse_cnt != p0 + 2) begin failures++; $display("FAIL rearm_pulses got=%0d exp=%0d", pulse_cnt, p0 + 2); end
      if (exp_q.size() != 0)   begin failures++; $display("FAIL btn_missing got=%0d pending exp=0", exp_q.size()); end
   endtask

   task automatic test_reset_mid();
      int n;
      wdt_en = 1'b0;
      wdt_reload = 8'd37;
      n = cyc + 1;
      exp_q.push_back('{2'b11, n, n});
      soft_req = 1'b1;
      tick();
      soft_req = 1'b0;
      tick();
      sys_rst_n = 1'b0;
      #1;
      checks += 4;
      if (trigger_reset !== 1'b0) begin failures++; $display("FAIL mid_rst_trigger got=%b exp=0", trigger_reset); end
      if (busy !== 1'b0)          begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
      if (last_cause !== 2'b00)   begin failures++; $display("FAIL mid_rst_cause got=%0d exp=0", last_cause); end
      if (wdt_count !== 8'd0)     begin failures++; $display("FAIL mid_rst_wdt got=%0d exp=0", wdt_count); end
      tick(); tick();
      sys_rst_n = 1'b1;
      tick();
      checks += 3;
      if (wdt_count !== 8'd37)    begin failures++; $display("FAIL post_rst_wdt got=%0d exp=37", wdt_count); end
      if (busy !== 1'b0)          begin failures++; $display("FAIL post_rst_busy got=%b exp=0", busy); end
      if (trigger_reset !== 1'b0) begin failures++; $display("FAIL post_rst_trigger got=%b exp=0", trigger_reset); end
      n = cyc + 1;
      exp_q.push_back('{2'b11, n, n});
      soft_req = 1'b1;
      tick();
      soft_req = 1'b0;
      checks += 2;
      if (trigger_reset !== 1'b1) begin failures++; $display("FAIL post_rst_accept got=%b exp=1", trigger_reset); end
      if (last_cause !== 2'b11)   begin failures++; $display("FAIL post_rst_cause got=%0d exp=3", last_cause); end
      repeat (P + H + 2) tick();
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL mid_missing got=%0d pending exp=0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_soft_req();
      test_back_to_back();
      test_wdt_expire();
      test_simultaneous();
      test_wdt_kick();
      test_button_bounce();
      test_button_press();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
